// File: rtl/processor_core_pkg.sv
// Shared definitions for the multi-cycle 10-bit processor core.
package processor_core_pkg;

   localparam int unsigned WORD_SIZE    = 10;
   localparam int unsigned ADDRESS_SIZE = 8;
   localparam int unsigned DATA_SIZE    = 8;
   localparam int unsigned REG_COUNT    = 4;
   localparam int unsigned REG_SEL_W    = 2;
   localparam int unsigned ABS_ADDR_W   = 7;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_EXEC  = 1'b1
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_NOT   = 4'd4,
      OP_SIZ   = 4'd5,
      OP_NOP   = 4'd6,
      OP_JUMP  = 4'd7,
      OP_STORE = 4'd8,
      OP_LOAD  = 4'd9,
      OP_SAVE  = 4'd10
   } opcode_t;

   // Two-bit ALU function, taken straight from IR[7:6] of the register ops
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   // Memory request presented by the core each cycle
   typedef struct packed {
      logic [ADDRESS_SIZE-1:0] addr;
      logic [WORD_SIZE-1:0]    wdata;
      logic                    write;
   } mem_req_t;

   // Full decode: every 10-bit pattern maps onto exactly one opcode
   function automatic opcode_t decode_op(input logic [WORD_SIZE-1:0] instr);
      opcode_t op;
      case (instr[9:6])
         4'b0000:          op = OP_ADD;
         4'b0001:          op = OP_SUB;
         4'b0010:          op = OP_AND;
         4'b0011:          op = OP_OR;
         4'b0100:          op = OP_NOT;
         4'b0101:          op = instr[5] ? OP_NOP : OP_SIZ;
         4'b0110, 4'b0111: op = OP_JUMP;
         4'b1000, 4'b1001: op = OP_STORE;
         4'b1010, 4'b1011: op = OP_LOAD;
         default:          op = OP_SAVE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/processor_core_alu.sv
// Combinational 8-bit ALU: add/sub/and/or selected by op, or bitwise NOT of a.
module processor_core_alu
   import processor_core_pkg::*;
(
   input  alu_op_t              op,
   input  logic                 invert,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   output logic [DATA_SIZE-1:0] result_c,
   output logic                 zero_c
);

   // Result select and zero detect
   always_comb begin
      result_c = '0;
      if (invert) begin
         result_c = ~a;
      end else begin
         case (op)
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            default: result_c = '0;
         endcase
      end
      zero_c = (result_c == '0);
   end

endmodule

// File: rtl/processor_core.sv
// Two-state (FETCH/EXEC) processor core driving a single-port program/data memory.
module processor_core
   import processor_core_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [WORD_SIZE-1:0]    mem_rdata,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]    mem_wdata,
   output logic                    mem_write,
   output logic [ADDRESS_SIZE-1:0] pc,
   output logic [DATA_SIZE-1:0]    r0,
   output logic                    zero
);

   state_t                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0]    ir_q, ir_d;
   logic [DATA_SIZE-1:0]    rf_q [REG_COUNT];
   logic [DATA_SIZE-1:0]    rf_d [REG_COUNT];
   logic                    zero_q, zero_d;

   mem_req_t                req;
   opcode_t                 op;
   alu_op_t                 alu_op;
   logic                    alu_invert;
   logic [REG_SEL_W-1:0]    ra, rb, rd;
   logic [DATA_SIZE-1:0]    alu_result;
   logic                    alu_zero;
   logic [ADDRESS_SIZE-1:0] abs_addr;

   assign op         = decode_op(ir_q);
   assign ra         = ir_q[5:4];
   assign rb         = ir_q[3:2];
   assign rd         = ir_q[1:0];
   assign alu_op     = alu_op_t'(ir_q[7:6]);
   assign alu_invert = (op == OP_NOT);
   assign abs_addr   = {1'b0, ir_q[ABS_ADDR_W-1:0]};

   processor_core_alu u_alu (
      .op       (alu_op),
      .invert   (alu_invert),
      .a        (rf_q[ra]),
      .b        (rf_q[rb]),
      .result_c (alu_result),
      .zero_c   (alu_zero)
   );

   // Next-state, commit values and memory request decode
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      rf_d       = rf_q;
      zero_d     = zero_q;
      req.addr   = pc_q;
      req.wdata  = WORD_SIZE'(rf_q[0]);
      req.write  = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (enable) begin
               ir_d    = mem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + ADDRESS_SIZE'(1);
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                  rf_d[rd] = alu_result;
                  zero_d   = alu_zero;
               end
               OP_SIZ: begin
                  if (zero_q) pc_d = pc_q + ADDRESS_SIZE'(2);
               end
               OP_JUMP: begin
                  pc_d = abs_addr;
               end
               OP_STORE: begin
                  req.addr  = abs_addr;
                  req.write = 1'b1;
               end
               OP_LOAD: begin
                  req.addr = abs_addr;
                  rf_d[0]  = mem_rdata[DATA_SIZE-1:0];
               end
               OP_SAVE: begin
                  rf_d[0] = ir_q[DATA_SIZE-1:0];
               end
               default: ;
            endcase
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         rf_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zero_q  <= zero_d;
         rf_q    <= rf_d;
      end
   end

   assign mem_addr  = req.addr;
   assign mem_wdata = req.wdata;
   assign mem_write = req.write;
   assign pc        = pc_q;
   assign r0        = rf_q[0];
   assign zero      = zero_q;

endmodule
